// File: rtl/rf_32_regfile.sv
// rf_32_regfile: 32-entry register file with two registered read ports and
// one write port. Every register is general purpose, including entry 0.
// Reads return the contents from before any same-cycle write, so a read that
// collides with a write sees the old value. The new value appears on the next
// enabled read. RST is synchronous and has priority over both enables.
module rf_32_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] Ra,
    input  logic [ADDR_W-1:0] Rb,
    input  logic [ADDR_W-1:0] Add,
    input  logic [DATA_W-1:0] D,
    input  logic              RD_en,
    input  logic              WR_en,
    output logic [DATA_W-1:0] Qa,
    output logic [DATA_W-1:0] Qb
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] qa_r;
    logic [DATA_W-1:0] qb_r;

    // One flop bank per entry. Clearing every entry in reset requires the
    // array to be built from flops rather than from a RAM macro.
    for (genvar g = 0; g < DEPTH; g++) begin : g_reg
        // Clear this entry on reset, otherwise load D when it is the write target.
        always_ff @(posedge CLK) begin
            if (RST) begin
                mem_r[g] <= {DATA_W{1'b0}};
            end else if (WR_en && (Add == ADDR_W'(g))) begin
                mem_r[g] <= D;
            end else begin
                mem_r[g] <= mem_r[g];
            end
        end
    end

    // Registered read ports. They sample the array before this edge's write
    // commits, which gives old-data behaviour on a read/write collision.
    always_ff @(posedge CLK) begin
        if (RST) begin
            qa_r <= {DATA_W{1'b0}};
            qb_r <= {DATA_W{1'b0}};
        end else if (RD_en) begin
            qa_r <= mem_r[Ra];
            qb_r <= mem_r[Rb];
        end else begin
            qa_r <= qa_r;
            qb_r <= qb_r;
        end
    end

    assign Qa = qa_r;
    assign Qb = qb_r;

endmodule

// File: tb/tb_rf_32_regfile.sv
// Bench for rf_32_regfile. It runs directed scenarios and then randomized
// traffic. The expected outputs come from an array-based reference model.
module tb_rf_32_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  add;
    logic [31:0] d;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] qa;
    logic [31:0] qb;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] ref_mem [32];
    logic [31:0] ref_qa;
    logic [31:0] ref_qb;

    rf_32_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .CLK   (clk),
        .RST   (rst),
        .Ra    (ra),
        .Rb    (rb),
        .Add   (add),
        .D     (d),
        .RD_en (rd_en),
        .WR_en (wr_en),
        .Qa    (qa),
        .Qb    (qb)
    );

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven,
    // then let the DUT take the same edge and settle.
    task automatic tick();
        if (rst) begin
            foreach (ref_mem[i]) ref_mem[i] = 32'h0000_0000;
            ref_qa = 32'h0000_0000;
            ref_qb = 32'h0000_0000;
        end else begin
            if (rd_en) begin
                ref_qa = ref_mem[ra];
                ref_qb = ref_mem[rb];
            end
            if (wr_en) ref_mem[add] = d;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        ref_qa = 32'h0000_0000;
        ref_qb = 32'h0000_0000;
        foreach (ref_mem[i]) ref_mem[i] = 32'h0000_0000;
        rst = 1'b0; ra = 5'd0; rb = 5'd0; add = 5'd0; d = 32'h0; rd_en = 1'b0; wr_en = 1'b0;
        @(negedge clk);

        // Reset
        rst = 1'b1;
        tick();
        check("reset_qa", qa, 32'h0000_0000);
        check("reset_qb", qb, 32'h0000_0000);

        // Two writes, then read both back
        idle(); wr_en = 1'b1; add = 5'd5;  d = 32'hA5A5_A5A5; tick();
        add = 5'd10; d = 32'h5A5A_5A5A; tick();
        idle(); rd_en = 1'b1; ra = 5'd5; rb = 5'd10; tick();
        check("write_read_qa", qa, 32'hA5A5_A5A5);
        check("write_read_qb", qb, 32'h5A5A_5A5A);

        // Unwritten registers read zero after reset
        ra = 5'd15; rb = 5'd20; tick();
        check("unwritten_qa", qa, 32'h0000_0000);
        check("unwritten_qb", qb, 32'h0000_0000);

        // Read hold with RD_en low
        ra = 5'd5; rb = 5'd5; tick();
        check("hold_load_qa", qa, 32'hA5A5_A5A5);
        rd_en = 1'b0; ra = 5'd10; rb = 5'd10; tick();
        check("hold_qa", qa, 32'hA5A5_A5A5);
        tick();
        check("hold_qa_2", qa, 32'hA5A5_A5A5);
        check("hold_qb_2", qb, 32'hA5A5_A5A5);

        // Read/write collision returns old data, new data next read
        wr_en = 1'b1; add = 5'd5; d = 32'h1234_5678; rd_en = 1'b1; ra = 5'd5; rb = 5'd5; tick();
        check("collide_qa", qa, 32'hA5A5_A5A5);
        check("collide_qb", qb, 32'hA5A5_A5A5);
        wr_en = 1'b0; tick();
        check("after_collide_qa", qa, 32'h1234_5678);

        // Reset wins over write and read
        rst = 1'b1; wr_en = 1'b1; add = 5'd10; d = 32'hFFFF_FFFF; rd_en = 1'b1; ra = 5'd10; rb = 5'd10; tick();
        check("rst_prio_qa", qa, 32'h0000_0000);
        check("rst_prio_qb", qb, 32'h0000_0000);
        idle(); rd_en = 1'b1; ra = 5'd10; rb = 5'd5; tick();
        check("rst_prio_reg10", qa, 32'h0000_0000);
        check("rst_prio_reg5", qb, 32'h0000_0000);

        // Address extremes
        idle(); wr_en = 1'b1; add = 5'd0;  d = 32'hDEAD_BEEF; tick();
        add = 5'd31; d = 32'hCAFE_F00D; tick();
        idle(); rd_en = 1'b1; ra = 5'd0; rb = 5'd31; tick();
        check("extreme_qa", qa, 32'hDEAD_BEEF);
        check("extreme_qb", qb, 32'hCAFE_F00D);

        // Fill every register with a distinct value, then read all in pairs
        idle(); wr_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            add = 5'(i);
            d = 32'h1000_0001 * (i + 1) ^ 32'h8000_0000;
            tick();
        end
        idle(); rd_en = 1'b1;
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i); rb = 5'(31 - i);
            tick();
            check("sweep_qa", qa, ref_qa);
            check("sweep_qb", qb, ref_qb);
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom_range(0, 59) == 0);
            wr_en = ($urandom_range(0, 9) < 7);
            rd_en = ($urandom_range(0, 9) < 7);
            add   = 5'($urandom_range(0, 31));
            ra    = ($urandom_range(0, 3) == 0) ? add : 5'($urandom_range(0, 31));
            rb    = ($urandom_range(0, 3) == 0) ? ra  : 5'($urandom_range(0, 31));
            d     = $urandom;
            #2;
            check("between_edges_qa", qa, ref_qa);
            check("between_edges_qb", qb, ref_qb);
            tick();
            check("rand_qa", qa, ref_qa);
            check("rand_qb", qb, ref_qb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
